// File: rtl/traffic_phase_timer.sv
// Phase sequencer for the traffic-light decoder: per-phase durations in seconds, hold, and
// optional pedestrian walk support built only when TRAFFIC_PED_EN is defined.
module traffic_phase_timer #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned GREEN_S      = 5,
    parameter int unsigned YELLOW_S     = 2,
    parameter int unsigned ALLRED_S     = 1,
    parameter int unsigned PED_S        = 4,
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_btn,
    input  logic       hold,
    output logic [2:0] phase,
    output logic       phase_start,
    output logic [3:0] sec_left,
    output logic       ped_pending,
    output logic       walk
);

    typedef enum logic [2:0] {
        PH_NS_GREEN  = 3'd0,
        PH_NS_YELLOW = 3'd1,
        PH_ALLRED_A  = 3'd2,
        PH_EW_GREEN  = 3'd3,
        PH_EW_YELLOW = 3'd4,
        PH_ALLRED_B  = 3'd5
    } phase_t;

    localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PS_MAX  = PW'(CLK_HZ - 1);
    localparam logic [3:0] GREEN_D    = 4'(GREEN_S);
    localparam logic [3:0] YELLOW_D   = 4'(YELLOW_S);
    localparam logic [3:0] ALLRED_D   = 4'(ALLRED_S);
    localparam logic [3:0] WALK_D     = 4'(ALLRED_S + PED_S);

    if (CLK_HZ < 2) begin : g_bad_clk
        $error("traffic_phase_timer: CLK_HZ must be at least 2");
    end
    if (GREEN_S < 1 || GREEN_S > 15) begin : g_bad_green
        $error("traffic_phase_timer: GREEN_S must be 1..15");
    end
    if (YELLOW_S < 1 || YELLOW_S > 15) begin : g_bad_yellow
        $error("traffic_phase_timer: YELLOW_S must be 1..15");
    end
    if (ALLRED_S < 1 || ALLRED_S > 15) begin : g_bad_allred
        $error("traffic_phase_timer: ALLRED_S must be 1..15");
    end
    if (ALLRED_S + PED_S < 1 || ALLRED_S + PED_S > 15) begin : g_bad_walk
        $error("traffic_phase_timer: ALLRED_S+PED_S must be 1..15");
    end
    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
        $error("traffic_phase_timer: DEBOUNCE_CYC must be at least 1");
    end

    phase_t        state;
    phase_t        next_state;
    logic [3:0]    sec_q;
    logic [3:0]    next_dur;
    logic          next_walk;
    logic          start_q;
    logic          walk_q;
    logic          pend_q;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic          is_green;
    logic          advance;

`ifdef TRAFFIC_PED_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYC);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync;
    logic [DW-1:0] db_cnt;
    logic          press;

    // Counter saturates at DB_MAX so a held button yields exactly one press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], ped_btn};
            press <= sync[1] && (db_cnt == DB_LAST);
            if (!sync[1]) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // A request is only consumed when a walk phase ends; a new press in that cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else if (press) begin
            pend_q <= 1'b1;
        end else if (advance && walk_q) begin
            pend_q <= 1'b0;
        end
    end
`else
    logic unused_ped_btn;
    assign unused_ped_btn = ped_btn;
    assign pend_q         = 1'b0;
`endif

    assign tick     = !hold && (pre_cnt == PS_MAX);
    assign is_green = (state == PH_NS_GREEN) || (state == PH_EW_GREEN);
    assign advance  = tick && ((sec_q == 4'd1) || (pend_q && is_green));

    always_comb begin
        next_state = PH_NS_GREEN;
        next_dur   = GREEN_D;
        next_walk  = 1'b0;
        case (state)
            PH_NS_GREEN:  begin next_state = PH_NS_YELLOW; next_dur = YELLOW_D; end
            PH_NS_YELLOW: begin next_state = PH_ALLRED_A;  next_dur = ALLRED_D; next_walk = pend_q; end
            PH_ALLRED_A:  begin next_state = PH_EW_GREEN;  next_dur = GREEN_D;  end
            PH_EW_GREEN:  begin next_state = PH_EW_YELLOW; next_dur = YELLOW_D; end
            PH_EW_YELLOW: begin next_state = PH_ALLRED_B;  next_dur = ALLRED_D; next_walk = pend_q; end
            PH_ALLRED_B:  begin next_state = PH_NS_GREEN;  next_dur = GREEN_D;  end
            default:      begin next_state = PH_NS_GREEN;  next_dur = GREEN_D;  end
        endcase
        if (next_walk) begin
            next_dur = WALK_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PH_NS_GREEN;
            sec_q   <= GREEN_D;
            start_q <= 1'b0;
            walk_q  <= 1'b0;
            pre_cnt <= '0;
        end else begin
            start_q <= 1'b0;
            if (!hold) begin
                pre_cnt <= (pre_cnt == PS_MAX) ? '0 : pre_cnt + PW'(1);
            end
            if (advance) begin
                state   <= next_state;
                sec_q   <= next_dur;
                start_q <= 1'b1;
                walk_q  <= next_walk;
            end else if (tick) begin
                sec_q <= sec_q - 4'd1;
            end
        end
    end

    assign phase       = state;
    assign phase_start = start_q;
    assign sec_left    = sec_q;
    assign ped_pending = pend_q;
    assign walk        = walk_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with CLK_HZ=4, GREEN_S=3, YELLOW_S=2, ALLRED_S=1,
// PED_S=4, DEBOUNCE_CYC=3; pedestrian scenarios run when TRAFFIC_PED_EN is defined.
module tb_traffic_phase_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ped_btn;
    logic       hold;
    logic [2:0] phase;
    logic       phase_start;
    logic [3:0] sec_left;
    logic       ped_pending;
    logic       walk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    traffic_phase_timer #(
        .CLK_HZ      (4),
        .GREEN_S     (3),
        .YELLOW_S    (2),
        .ALLRED_S    (1),
        .PED_S       (4),
        .DEBOUNCE_CYC(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ped_btn    (ped_btn),
        .hold       (hold),
        .phase      (phase),
        .phase_start(phase_start),
        .sec_left   (sec_left),
        .ped_pending(ped_pending),
        .walk       (walk)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench just after the last reset edge ("edge 0").
    task automatic do_reset();
        rst     = 1'b1;
        hold    = 1'b0;
        ped_btn = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Expected free-running outputs k edges after reset release: 12,8,4,12,8,4 cycles.
    function automatic void free_ref(input int k, output logic [2:0] ph,
                                     output logic [3:0] sl, output logic st);
        int bnd[7] = '{0, 12, 20, 24, 36, 44, 48};
        int dur[6] = '{3, 2, 1, 3, 2, 1};
        int km = k % 48;
        ph = 3'd0;
        sl = 4'd0;
        st = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (km >= bnd[i] && km < bnd[i+1]) begin
                ph = 3'(i);
                sl = 4'(dur[i] - (km - bnd[i]) / 4);
                st = (km == bnd[i]) && (k > 0);
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; ped_btn = 1'b0;
        step(3);
        n_total++; if (phase !== 3'd0) $display("FAIL reset_phase: got %0d want 0", phase); else n_pass++;
        n_total++; if (sec_left !== 4'd3) $display("FAIL reset_sec_left: got %0d want 3", sec_left); else n_pass++;
        n_total++; if (phase_start !== 1'b0) $display("FAIL reset_phase_start: got %b want 0", phase_start); else n_pass++;
        n_total++; if (ped_pending !== 1'b0) $display("FAIL reset_ped_pending: got %b want 0", ped_pending); else n_pass++;
        n_total++; if (walk !== 1'b0) $display("FAIL reset_walk: got %b want 0", walk); else n_pass++;
    endtask

    // Button is held high for the first btn_cycles edges after reset release.
    task automatic test_free_run(input int btn_cycles);
        logic [2:0] eph;
        logic [3:0] esl;
        logic       est;
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            ped_btn = (k <= btn_cycles);
            step(1);
            free_ref(k, eph, esl, est);
            n_total++; if (phase !== eph) $display("FAIL free_phase k=%0d btn=%0d: got %0d want %0d", k, btn_cycles, phase, eph); else n_pass++;
            n_total++; if (sec_left !== esl) $display("FAIL free_sec_left k=%0d btn=%0d: got %0d want %0d", k, btn_cycles, sec_left, esl); else n_pass++;
            n_total++; if (phase_start !== est) $display("FAIL free_phase_start k=%0d btn=%0d: got %b want %b", k, btn_cycles, phase_start, est); else n_pass++;
            n_total++; if (ped_pending !== 1'b0) $display("FAIL free_ped_pending k=%0d btn=%0d: got %b want 0", k, btn_cycles, ped_pending); else n_pass++;
            n_total++; if (walk !== 1'b0) $display("FAIL free_walk k=%0d btn=%0d: got %b want 0", k, btn_cycles, walk); else n_pass++;
        end
        ped_btn = 1'b0;
    endtask

    // Hold covers edges 4..13, including the first tick, so phase 0 stretches to 22 cycles.
    task automatic test_hold();
        do_reset();
        step(3);
        hold = 1'b1;
        for (int k = 4; k <= 13; k++) begin
            step(1);
            n_total++; if (sec_left !== 4'd3) $display("FAIL hold_sec_left k=%0d: got %0d want 3", k, sec_left); else n_pass++;
        end
        hold = 1'b0;
        step(1);
        n_total++; if (sec_left !== 4'd2) $display("FAIL hold_first_tick: got %0d want 2", sec_left); else n_pass++;
        step(7);
        n_total++; if (phase !== 3'd0) $display("FAIL hold_phase_k21: got %0d want 0", phase); else n_pass++;
        step(1);
        n_total++; if (phase !== 3'd1) $display("FAIL hold_phase_k22: got %0d want 1", phase); else n_pass++;
        n_total++; if (phase_start !== 1'b1) $display("FAIL hold_start_k22: got %b want 1", phase_start); else n_pass++;
        n_total++; if (sec_left !== 4'd2) $display("FAIL hold_sec_k22: got %0d want 2", sec_left); else n_pass++;
    endtask

`ifdef TRAFFIC_PED_EN
    task automatic test_ped_walk();
        do_reset();
        ped_btn = 1'b1;
        step(5);
        n_total++; if (ped_pending !== 1'b0) $display("FAIL walk_pend_k5: got %b want 0", ped_pending); else n_pass++;
        step(1);
        n_total++; if (ped_pending !== 1'b1) $display("FAIL walk_pend_k6: got %b want 1", ped_pending); else n_pass++;
        step(1);
        n_total++; if (phase !== 3'd0) $display("FAIL walk_phase_k7: got %0d want 0", phase); else n_pass++;
        step(1);
        ped_btn = 1'b0;
        n_total++; if (phase !== 3'd1) $display("FAIL walk_trunc_phase_k8: got %0d want 1", phase); else n_pass++;
        n_total++; if (phase_start !== 1'b1) $display("FAIL walk_trunc_start_k8: got %b want 1", phase_start); else n_pass++;
        n_total++; if (sec_left !== 4'd2) $display("FAIL walk_yellow_sec_k8: got %0d want 2", sec_left); else n_pass++;
        step(7);
        n_total++; if (phase !== 3'd1 || walk !== 1'b0) $display("FAIL walk_yellow_k15: got phase %0d walk %b want 1/0", phase, walk); else n_pass++;
        step(1);
        n_total++; if (phase !== 3'd2) $display("FAIL walk_phase_k16: got %0d want 2", phase); else n_pass++;
        n_total++; if (walk !== 1'b1) $display("FAIL walk_flag_k16: got %b want 1", walk); else n_pass++;
        n_total++; if (sec_left !== 4'd5) $display("FAIL walk_sec_k16: got %0d want 5", sec_left); else n_pass++;
        n_total++; if (ped_pending !== 1'b1) $display("FAIL walk_pend_k16: got %b want 1", ped_pending); else n_pass++;
        step(4);
        n_total++; if (sec_left !== 4'd4) $display("FAIL walk_sec_k20: got %0d want 4", sec_left); else n_pass++;
        step(15);
        n_total++; if (phase !== 3'd2 || walk !== 1'b1) $display("FAIL walk_end_k35: got phase %0d walk %b want 2/1", phase, walk); else n_pass++;
        step(1);
        n_total++; if (phase !== 3'd3) $display("FAIL walk_exit_phase_k36: got %0d want 3", phase); else n_pass++;
        n_total++; if (walk !== 1'b0) $display("FAIL walk_exit_walk_k36: got %b want 0", walk); else n_pass++;
        n_total++; if (ped_pending !== 1'b0) $display("FAIL walk_exit_pend_k36: got %b want 0", ped_pending); else n_pass++;
        n_total++; if (sec_left !== 4'd3) $display("FAIL walk_exit_sec_k36: got %0d want 3", sec_left); else n_pass++;
    endtask
`endif

    // Reset lands at edge 31, inside phase 3 (and with a request pending in the walk build).
    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 30; k++) begin
`ifdef TRAFFIC_PED_EN
            ped_btn = (k >= 25);
`endif
            step(1);
        end
        n_total++; if (phase !== 3'd3) $display("FAIL mid_pre_phase: got %0d want 3", phase); else n_pass++;
`ifdef TRAFFIC_PED_EN
        n_total++; if (ped_pending !== 1'b1) $display("FAIL mid_pre_pend: got %b want 1", ped_pending); else n_pass++;
`endif
        rst = 1'b1;
        step(1);
        n_total++; if (phase !== 3'd0) $display("FAIL mid_phase: got %0d want 0", phase); else n_pass++;
        n_total++; if (sec_left !== 4'd3) $display("FAIL mid_sec_left: got %0d want 3", sec_left); else n_pass++;
        n_total++; if (ped_pending !== 1'b0) $display("FAIL mid_pend: got %b want 0", ped_pending); else n_pass++;
        n_total++; if (walk !== 1'b0) $display("FAIL mid_walk: got %b want 0", walk); else n_pass++;
        n_total++; if (phase_start !== 1'b0) $display("FAIL mid_start: got %b want 0", phase_start); else n_pass++;
        rst = 1'b0;
        ped_btn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; ped_btn = 1'b0;
        test_reset();
        test_free_run(0);
        test_hold();
`ifdef TRAFFIC_PED_EN
        test_ped_walk();
        test_free_run(2);
`else
        test_free_run(1000);
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
